// File: rtl/srl_fifo_pkg.sv
// Shared constants and occupancy arithmetic for the 16-deep SRL FIFO.
// Latency: n/a (package).
// Backpressure: n/a (package).
package srl_fifo_pkg;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;

    // Occupancy after one cycle; a simultaneous push and pop leave it unchanged.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             wr_ok,
        input logic             rd_ok
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (wr_ok && !rd_ok)
            res = cnt + CNT_W'(1);
        else if (rd_ok && !wr_ok)
            res = cnt - CNT_W'(1);
        return res;
    endfunction

endpackage

// File: rtl/srl16_slice.sv
// One bit-slice of storage: 16-tap shift register with enable and addressable tap.
// Latency: shift on the enabling edge; tap read is combinational.
// Backpressure: none, the caller decides when to shift.
module srl16_slice
    import srl_fifo_pkg::*;
#(
    parameter logic [DEPTH-1:0] INIT = '0
) (
    input  logic              clk_in,
    input  logic              ce,
    input  logic              d,
    input  logic [ADDR_W-1:0] addr,
    output logic              q
);

    // Storage carries no reset so it maps onto SRL primitives.
    logic [DEPTH-1:0] sr = INIT;

    // Shift toward higher taps; newest bit always lands in tap 0.
    always_ff @(posedge clk_in) begin
        if (ce)
            sr <= {sr[DEPTH-2:0], d};
    end

    // Addressable tap, read combinationally.
    always_comb begin
        q = sr[addr];
    end

endmodule

// File: rtl/srl16_fifo_ctrl.sv
// 16-deep first-word-fall-through FIFO on shift-register storage plus occupancy/flags.
// Latency: written word visible on dout right after the accepting edge.
// Backpressure: writes refused while full unless paired with a read; refused requests pulse overflow/underflow.
module srl16_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 12
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    logic              wr_ok;
    logic              rd_ok;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] rd_addr;

    // Accept decisions; a write into a full FIFO is fine when a read frees the oldest slot.
    always_comb begin
        wr_ok   = wr_en & (~full | rd_en);
        rd_ok   = rd_en & ~empty;
        cnt_nxt = next_count(count, wr_ok, rd_ok);
        // Oldest entry sits at tap count-1; wraps to 15 when count is 16.
        rd_addr = count[ADDR_W-1:0] - ADDR_W'(1);
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            srl16_slice u_slice (
                .clk_in (clk_in),
                .ce     (wr_ok),
                .d      (din[i]),
                .addr   (rd_addr),
                .q      (dout[i])
            );
        end
    endgenerate

    // Occupancy, flags derived from the next count so they never lag it, and reject pulses.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= cnt_nxt;
            empty       <= (cnt_nxt == '0);
            full        <= (cnt_nxt == CNT_W'(DEPTH));
            almost_full <= (cnt_nxt >= CNT_W'(AF_LEVEL));
            overflow    <= wr_en & ~wr_ok;
            underflow   <= rd_en & ~rd_ok;
        end
    end

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Self-checking bench: directed FIFO scenarios plus random traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_srl16_fifo_ctrl;

    localparam int W  = 8;
    localparam int AF = 12;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [W-1:0] din;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic [4:0]   count;
    logic         overflow;
    logic         underflow;

    srl16_fifo_ctrl #(.WIDTH(W), .AF_LEVEL(AF)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk_in = ~clk_in;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] mq[$];
    bit           exp_ovf = 1'b0;
    bit           exp_ufl = 1'b0;
    logic [W-1:0] last_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every visible output against the queue model.
    task automatic check_state();
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_ufl));
        if (mq.size() > 0)
            chk("dout", 32'(dout), 32'(mq[0]));
    endtask

    // One cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
        bit           wa;
        bit           ra;
        logic [W-1:0] seen;
        wr_en = wr;
        din   = d;
        rd_en = rd;
        #1;
        check_state();
        seen = dout;
        @(posedge clk_in);
        ra = rd && (mq.size() > 0);
        wa = wr && ((mq.size() < 16) || rd);
        if (ra) begin
            last_pop = seen;
            void'(mq.pop_front());
        end
        if (wa)
            mq.push_back(d);
        exp_ovf = wr && !wa;
        exp_ufl = rd && !ra;
        @(negedge clk_in);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++)
            step(1'b1, W'(i + 1), 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #2;
        check_state();
        @(negedge clk_in);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Fill 1..16, watching almost_full's first rise and full.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, W'(i + 1), 1'b0);
            if (i == 10) chk("af_after_11", 32'(almost_full), 32'd0);
            if (i == 11) chk("af_after_12", 32'(almost_full), 32'd1);
        end
        chk("full_after_16", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            chk("drain_seq", 32'(last_pop), 32'(i + 1));
        end
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Overflow at full must not disturb contents.
        fill_ramp();
        step(1'b1, W'('hAA), 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        step(1'b0, '0, 1'b0);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            chk("ovf_drain_seq", 32'(last_pop), 32'(i + 1));
        end

        // Simultaneous read/write while full.
        fill_ramp();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, W'('h55), 1'b1);
            chk("rw_full_pop", 32'(last_pop), 32'(i + 1));
            chk("rw_full_count", 32'(count), 32'd16);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            chk("rw_drain_seq", 32'(last_pop), (i < 12) ? 32'(i + 5) : 32'h55);
        end

        // Read plus write on empty: read refused, write taken.
        step(1'b1, W'('h3C), 1'b1);
        chk("ufl_pulse", 32'(underflow), 32'd1);
        chk("ufl_count", 32'(count), 32'd1);
        chk("ufl_dout", 32'(dout), 32'h3C);
        step(1'b0, '0, 1'b1);
        chk("ufl_pop", 32'(last_pop), 32'h3C);

        // Asynchronous reset mid-stream at count 7.
        for (int i = 0; i < 7; i++)
            step(1'b1, W'(i + 'h20), 1'b0);
        chk("pre_rst_count", 32'(count), 32'd7);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        mq.delete();
        exp_ovf = 1'b0;
        exp_ufl = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++)
            step(1'($urandom % 2), W'($urandom), 1'($urandom % 2));
        step(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
